// File: rtl/mips_pkg.sv
// Shared defaults for the register file slice.
// Hardwired zero register index lives here too.
package mips_pkg;

    localparam int DATA_W_DEF   = 32;
    localparam int NUM_REGS_DEF = 32;
    localparam int NUM_RD_DEF   = 2;
    localparam int ZERO_REG     = 0;

endpackage

// File: rtl/regfile_sb_if.sv
// Read, writeback, issue and scoreboard signals of regfile_sb.
// master drives addresses/strobes, slave returns data and busy state.
interface regfile_sb_if
    import mips_pkg::*;
#(
    parameter  int DATA_W   = DATA_W_DEF,
    parameter  int NUM_REGS = NUM_REGS_DEF,
    parameter  int NUM_RD   = NUM_RD_DEF,
    localparam int ADDR_W   = $clog2(NUM_REGS)
);

    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic                     iss_en;
    logic [ADDR_W-1:0]        iss_addr;
    logic [ADDR_W:0]          busy_cnt;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data,
        output iss_en, iss_addr,
        input  rd_data, rd_busy, busy_cnt
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data,
        input  iss_en, iss_addr,
        output rd_data, rd_busy, busy_cnt
    );

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register pending-write bits and a registered popcount of them.
// Issue beats writeback to the same register (newer producer wins).
module regfile_scoreboard
    import mips_pkg::*;
#(
    parameter  int NUM_REGS = NUM_REGS_DEF,
    localparam int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                iss_en,
    input  logic [ADDR_W-1:0]   iss_addr,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    output logic [NUM_REGS-1:0] busy,
    output logic [ADDR_W:0]     busy_cnt
);

    localparam logic [ADDR_W-1:0] ZA = ADDR_W'(ZERO_REG);

    logic                iss_ok;
    logic                wr_ok;
    logic                set;
    logic                clr;
    logic [NUM_REGS-1:0] busy_nxt;
    logic [ADDR_W:0]     cnt_nxt;

    always_comb begin
        iss_ok   = en && iss_en && (iss_addr != ZA);
        wr_ok    = en && wr_en && (wr_addr != ZA);
        set      = iss_ok && !busy[iss_addr];
        clr      = wr_ok && busy[wr_addr] &&
                   !(iss_ok && (iss_addr == wr_addr));
        busy_nxt = busy;
        if (wr_ok)
            busy_nxt[wr_addr] = 1'b0;
        if (iss_ok)
            busy_nxt[iss_addr] = 1'b1;
        busy_nxt[ZERO_REG] = 1'b0;
        cnt_nxt  = busy_cnt + (ADDR_W+1)'(set) - (ADDR_W+1)'(clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            busy     <= busy_nxt;
            busy_cnt <= cnt_nxt;
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Register file with zero-latency reads and a pending-write scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle writeback to reads.
module regfile_sb
    import mips_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int NUM_RD   = NUM_RD_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    regfile_sb_if.slave  rf
);

    localparam int ADDR_W = $clog2(NUM_REGS);
    localparam logic [ADDR_W-1:0] ZA = ADDR_W'(ZERO_REG);

    logic                live;
    logic                wr_ok;
    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy;

    // First edge after reset release is swallowed so a strobe
    // racing the release never lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            live <= 1'b0;
        else
            live <= 1'b1;
    end

    assign wr_ok = live && rf.wr_en && (rf.wr_addr != ZA);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++)
                regs[i] <= '0;
        end else if (wr_ok) begin
            regs[rf.wr_addr] <= rf.wr_data;
        end
    end

    regfile_scoreboard #(
        .NUM_REGS (NUM_REGS)
    ) u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (live),
        .iss_en   (rf.iss_en),
        .iss_addr (rf.iss_addr),
        .wr_en    (rf.wr_en),
        .wr_addr  (rf.wr_addr),
        .busy     (busy),
        .busy_cnt (rf.busy_cnt)
    );

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        logic              b;

        assign a = rf.rd_addr[i*ADDR_W +: ADDR_W];

        always_comb begin
            d = (a == ZA) ? '0 : regs[a];
            b = busy[a];
`ifdef REGFILE_BYPASS_EN
            if (wr_ok && (a == rf.wr_addr)) begin
                d = rf.wr_data;
                b = rf.iss_en && (rf.iss_addr == rf.wr_addr);
            end
`endif
        end

        assign rf.rd_data[i*DATA_W +: DATA_W] = d;
        assign rf.rd_busy[i]                  = b;
    end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register width in bits.
REQ-002 SHALL have parameter NUM_REGS, default 32, register count (power of two, >=2).
REQ-003 SHALL have parameter NUM_RD, default 2, number of independent read ports (1..4).
REQ-004 SHALL have derived parameter ADDR_W = clog2(NUM_REGS), not overridable.
REQ-005 SHALL have port clk, input, 1, sole clock; all state updates on the rising edge.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port rd_addr, input, NUM_RD*ADDR_W, packed read addresses; port i uses slice i.
REQ-008 SHALL have port rd_data, output, NUM_RD*DATA_W, packed read data.
REQ-009 SHALL have port rd_busy, output, NUM_RD, per-port pending-write flag.
REQ-010 SHALL have port wr_en, input, 1, writeback strobe.
REQ-011 SHALL have port wr_addr, input, ADDR_W, writeback destination.
REQ-012 SHALL have port wr_data, input, DATA_W, writeback value.
REQ-013 SHALL have port iss_en, input, 1, issue strobe marking a destination pending.
REQ-014 SHALL have port iss_addr, input, ADDR_W, issued destination.
REQ-015 SHALL have port busy_cnt, output, ADDR_W+1, number of pending registers.

Function
REQ-016 SHALL return register contents on rd_data combinationally (zero-cycle read latency).
REQ-017 SHALL write wr_data to wr_addr on the rising edge when wr_en=1.
REQ-018 SHALL hardwire register 0: reads return 0, writes and issues to it are ignored, never busy.
REQ-019 SHALL keep one busy bit per register; iss_en sets busy[iss_addr], wr_en clears busy[wr_addr].
REQ-020 SHALL, on iss_en and wr_en to the same nonzero address in one cycle, leave the bit set (newer producer wins).
REQ-021 SHALL drive rd_busy[i] = busy[rd_addr_i], subject to REQ-030.
REQ-022 SHALL ignore a write to a register that is not busy only for scoreboard purposes; data is still written.
REQ-023 SHALL update busy_cnt as a registered counter: +1 on set of a clear bit, -1 on clear of a set bit, net 0 when both occur on different addresses.
REQ-024 SHALL never let busy_cnt exceed NUM_REGS-1 or underflow below 0.
REQ-025 SHALL keep busy_cnt equal to the popcount of the busy bits at all times.

Reset
REQ-026 SHALL, while rst_n=0, clear all registers to 0, all busy bits to 0 and busy_cnt to 0, independent of clk.
REQ-027 SHALL drive rd_data=0 and rd_busy=0 during reset.
REQ-028 SHALL discard any wr_en or iss_en coinciding with the edge on which rst_n is released.

Configuration
REQ-029 SHALL use macro REGFILE_BYPASS_EN to select write-to-read forwarding.
REQ-030 SHALL, with REGFILE_BYPASS_EN defined, return wr_data and rd_busy[i]=0 when wr_en=1 and rd_addr_i=wr_addr!=0, unless iss_en=1 with iss_addr=wr_addr, in which case rd_busy[i]=1.
REQ-031 SHALL, without REGFILE_BYPASS_EN, return the pre-edge stored value and pre-edge busy bit on such reads.

Structure
REQ-032 SHALL place default DATA_W, NUM_REGS, NUM_RD and the zero-register index in shared package mips_pkg.
REQ-033 SHALL implement the busy bits and busy_cnt in a sub-module regfile_scoreboard; storage and read muxes stay in regfile_sb.

Verification
REQ-034 Reset then read all addresses -> rd_data=0, rd_busy=0, busy_cnt=0.
REQ-035 Write 0xDEADBEEF to r5, next cycle read r5 on both ports -> 0xDEADBEEF on both.
REQ-036 Write 0x12345678 to r0 and issue r0 -> r0 reads 0, busy_cnt stays 0.
REQ-037 Issue r7, r9; writeback r7 -> busy_cnt 1,2,1; rd_busy for r9 =1, for r7 =0.
REQ-038 Same cycle wr r3=0xA5A5A5A5 and read r3 -> 0xA5A5A5A5 with REGFILE_BYPASS_EN, old value without.
REQ-039 Issue r4, then assert rst_n=0 mid-cycle -> busy bits and busy_cnt clear immediately, r4 reads 0.
